// File: rtl/pid_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pwm_driver
//  Purpose  : Fixed-period (255 tick) PWM actuator stage with shadowed duty,
//             period-boundary duty load and optional slew limiting
//             (compile-time macro PWM_SLEW_LIMIT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module pid_pwm_driver #(
    parameter int PRESCALE = 1,
    parameter int MAX_STEP = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty_active
);

    localparam int                 c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [7:0]         c_CNT_LAST = 8'd254;

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("pid_pwm_driver: PRESCALE must be >= 1");
        end
        if (MAX_STEP < 1 || MAX_STEP > 255) begin : g_bad_max_step
            $error("pid_pwm_driver: MAX_STEP must be in 1..255");
        end
    endgenerate

    logic               run_q,     run_d;
    logic [c_PRE_W-1:0] pre_q,     pre_d;
    logic [7:0]         cnt_q,     cnt_d;
    logic [7:0]         pending_q, pending_d;
    logic [7:0]         duty_q,    duty_d;

    logic       w_tick;
    logic       w_wrap;
    logic [7:0] w_target;
    logic [7:0] w_limited;

    assign w_tick   = (pre_q == c_PRE_LAST);
    assign w_wrap   = run_q && w_tick && (cnt_q == c_CNT_LAST);
    // A strobe coincident with the wrap must reach the next period directly.
    assign w_target = duty_valid ? duty_in : pending_q;

`ifdef PWM_SLEW_LIMIT_EN
    localparam logic [8:0] c_STEP = 9'(MAX_STEP);

    logic [8:0] w_up;
    logic [8:0] w_tgt9;

    assign w_up   = {1'b0, duty_q} + c_STEP;
    assign w_tgt9 = {1'b0, w_target};

    always_comb begin
        w_limited = w_target;
        if (w_tgt9 > w_up) begin
            w_limited = w_up[7:0];
        end else if ((w_tgt9 + c_STEP) < {1'b0, duty_q}) begin
            w_limited = duty_q - c_STEP[7:0];
        end
    end
`else
    assign w_limited = w_target;
`endif

    always_comb begin
        run_d     = run_q;
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        pending_d = w_target;
        duty_d    = duty_q;

        if (!enable) begin
            // Idle: counters parked, duty follows the request for presetting.
            run_d  = 1'b0;
            pre_d  = '0;
            cnt_d  = '0;
            duty_d = w_target;
        end else if (!run_q) begin
            run_d = 1'b1;
            pre_d = '0;
            cnt_d = '0;
        end else begin
            if (w_tick) begin
                pre_d = '0;
                cnt_d = w_wrap ? 8'd0 : (cnt_q + 8'd1);
            end else begin
                pre_d = pre_q + c_PRE_ONE;
            end
            if (w_wrap) begin
                duty_d = w_limited;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            pre_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            duty_q    <= '0;
        end else begin
            run_q     <= run_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            duty_q    <= duty_d;
        end
    end

    assign pwm_out      = run_q && (cnt_q < duty_q);
    assign period_start = run_q && (cnt_q == 8'd0) && (pre_q == '0);
    assign duty_active  = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_pwm_driver
//  Purpose  : Self-checking bench: period-level scoreboard for PRESCALE=1 plus
//             directed reset / PRESCALE=4 / enable-abort checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pid_pwm_driver;

    localparam int c_STEP = 16;
    localparam int c_NP   = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en1, dv1, pwm1, ps1;
    logic [7:0] din1, da1;
    logic       en4, dv4, pwm4, ps4;
    logic [7:0] din4, da4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pid_pwm_driver #(.PRESCALE(1), .MAX_STEP(c_STEP)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .duty_in(din1),
        .duty_valid(dv1), .pwm_out(pwm1), .period_start(ps1), .duty_active(da1)
    );

    pid_pwm_driver #(.PRESCALE(4), .MAX_STEP(c_STEP)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .duty_in(din4),
        .duty_valid(dv4), .pwm_out(pwm4), .period_start(ps4), .duty_active(da4)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: next period's duty from the previous one and the request.
    function automatic int model_next(input int active, input int target);
`ifdef PWM_SLEW_LIMIT_EN
        if (target > active + c_STEP) return active + c_STEP;
        if (target < active - c_STEP) return active - c_STEP;
`endif
        return target;
    endfunction

    function automatic int pick_duty();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return 0;
        if (r < 4) return 255;
        return int'($urandom_range(0, 255));
    endfunction

    // ---------------- scoreboard monitor (dut1) ----------------
    int unsigned exp_q[$];
    bit sb_on    = 1'b0;
    bit mon_open = 1'b0;
    int mon_len, mon_high, mon_duty;
    bit mon_stable;

    always @(negedge clk) begin
        if (!sb_on) begin
            mon_open = 1'b0;
        end else if (ps1) begin
            if (mon_open) chk("period_len", mon_len, 255);
            mon_open   = 1'b1;
            mon_len    = 1;
            mon_high   = int'(pwm1);
            mon_duty   = int'(da1);
            mon_stable = 1'b1;
        end else if (mon_open) begin
            mon_len++;
            mon_high += int'(pwm1);
            if (int'(da1) != mon_duty) mon_stable = 1'b0;
            if (mon_len == 255) begin
                mon_open = 1'b0;
                chk("sb_has_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    int e;
                    e = int'(exp_q.pop_front());
                    chk("period_duty", mon_duty, e);
                    chk("period_high", mon_high, e);
                    chk("duty_stable", int'(mon_stable), 1);
                end
            end
        end
    end

    // ---------------- PRESCALE=4 period measurement ----------------
    task automatic measure4(output int high, output int starts);
        high   = 0;
        starts = 0;
        for (int k = 0; k < 1020; k++) begin
            @(negedge clk);
            high   += int'(pwm4);
            starts += int'(ps4);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_active, pend, h, s;
        bit strobe;
        int sval;

        rst_n = 1'b0;
        en1 = 1'b0; dv1 = 1'b0; din1 = 8'd0;
        en4 = 1'b0; dv4 = 1'b0; din4 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm", int'(pwm1), 0);
        chk("reset_duty", int'(da1), 0);
        rst_n = 1'b1;

        // ---- asynchronous reset mid-period ----
        @(posedge clk); #1 dv1 = 1'b1; din1 = 8'd100;
        @(posedge clk); #1 dv1 = 1'b0;
        chk("preset_100", int'(da1), 100);
        en1 = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        chk("pwm_before_reset", int'(pwm1), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm1), 0);
        chk("async_rst_ps", int'(ps1), 0);
        chk("async_rst_duty", int'(da1), 0);
        en1 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_pwm", int'(pwm1), 0);
            chk("idle_ps", int'(ps1), 0);
            chk("idle_duty", int'(da1), 0);
        end

        // ---- scoreboard phase, PRESCALE=1 ----
        @(posedge clk); #1 dv1 = 1'b1; din1 = 8'd64;
        @(posedge clk); #1 dv1 = 1'b0;
        chk("preset_64", int'(da1), 64);
        exp_active = 64;
        pend       = 64;
        exp_q.push_back(64);
        sb_on = 1'b1;
        en1   = 1'b1;
        @(posedge clk);
        for (int p = 0; p < c_NP; p++) begin
            for (int c = 0; c < 255; c++) begin
                #1;
                dv1    = 1'b0;
                strobe = 1'b0;
                sval   = 0;
                if (p == 0 && c == 30)       begin strobe = 1'b1; sval = 200; end
                else if (p == 0 && c == 100) begin strobe = 1'b1; sval = 180; end
                else if (p == 1 && c == 254) begin strobe = 1'b1; sval = 90;  end
                else if (p == 2 && c == 10)  begin strobe = 1'b1; sval = 0;   end
                else if (p == 5 && c == 10)  begin strobe = 1'b1; sval = 255; end
                else if (p >= 8 && ($urandom_range(0, 99) < 2 ||
                         (c == 254 && $urandom_range(0, 2) == 0))) begin
                    strobe = 1'b1;
                    sval   = pick_duty();
                end
                if (strobe) begin
                    dv1  = 1'b1;
                    din1 = 8'(sval);
                    pend = sval;
                end
                if (p == c_NP - 1 && c == 254) en1 = 1'b0;
                @(posedge clk);
            end
            exp_active = model_next(exp_active, pend);
            if (p < c_NP - 1) exp_q.push_back(exp_active);
        end
        #1 dv1 = 1'b0;
        repeat (5) @(posedge clk);
        chk("sb_drained", int'(exp_q.size()), 0);
        chk("mon_closed", int'(mon_open), 0);
        chk("dis_no_pwm", int'(pwm1), 0);
        sb_on = 1'b0;

        // ---- PRESCALE=4, duty 10 ----
        @(posedge clk); #1 dv4 = 1'b1; din4 = 8'd10;
        @(posedge clk); #1 dv4 = 1'b0;
        en4 = 1'b1;
        @(posedge clk);
        measure4(h, s);
        chk("p4_high", h, 40);
        chk("p4_starts", s, 1);
        @(negedge clk);
        chk("p4_next_start", int'(ps4), 1);
        // now in clock 0 of the second period; cnt 50 spans clocks 200..203
        repeat (201) @(negedge clk);
        en4 = 1'b0;
        @(posedge clk); #1;
        chk("p4_abort_pwm", int'(pwm4), 0);
        chk("p4_abort_ps", int'(ps4), 0);
        chk("p4_abort_duty", int'(da4), 10);
        repeat (4) @(posedge clk);
        #1 en4 = 1'b1;
        @(posedge clk);
        measure4(h, s);
        chk("p4_reen_high", h, 40);
        chk("p4_reen_starts", s, 1);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("p4_mid_high", int'(pwm4), 1);
        en4 = 1'b0;
        @(posedge clk); #1;
        chk("p4_drop_pwm", int'(pwm4), 0);
        s = 0;
        repeat (10) begin
            @(negedge clk);
            s += int'(ps4) + int'(pwm4);
        end
        chk("p4_quiet", s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pid_pwm_driver.md
# pid_pwm_driver

Downstream actuator stage for the PID controller. It takes the 8-bit control signal the controller produces and turns it into a fixed-period PWM waveform. A shadow register captures new duty values at any time, and the active duty changes only at period boundaries, so the output never glitches. An optional slew limiter restricts the duty step applied per period.

## Interface
Parameters:
- PRESCALE, default 1: clocks per PWM count tick (legal range ≥1).
- MAX_STEP, default 16: maximum duty change per period when slew limiting is compiled in (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock domain; reset is asynchronous and active-low.
- enable  input  1  run request; sampled on clk.
- duty_in  input  8  requested duty (controller control signal), 0..255.
- duty_valid  input  1  one-cycle strobe; captures duty_in.
- pwm_out  output  1  PWM waveform.
- period_start  output  1  high during the first clock of each running period.
- duty_active  output  8  duty applied in the current period.

## Operation
- Registers:
  - run: registered copy of enable.
  - pre: prescaler, 0..PRESCALE-1.
  - cnt: period counter, 0..254.
  - pending: shadow duty.
  - duty_active.
- tick is asserted when pre == PRESCALE-1.
- While running (run = 1):
  - pre increments every clock and wraps to 0 on tick.
  - cnt increments on tick; wrap occurs when cnt == 254 and tick, setting cnt to 0.
- Each period is 255 ticks, so the period length is 255·PRESCALE clocks.
- pwm_out = run && (cnt < duty_active). This is a decode of registers only; it has no input-to-output combinational path.
  - duty 0 gives a constant low output.
  - duty 255 gives a constant high output.
- period_start = run && cnt == 0 && pre == 0.
- Duty capture:
  - duty_valid sets pending ← duty_in.
  - Multiple strobes within one period: the last one wins.
- Duty load, at wrap:
  - target = duty_valid ? duty_in : pending, so a strobe on the wrap cycle takes effect in the next period.
  - duty_active ← target, or the slew-limited target (see Configuration).
- Disabled (enable sampled low):
  - Next state is run = 0, pre = 0, cnt = 0.
  - duty_active ← target every cycle. This is a direct load with no slew limiting and lets software preset the duty.
- Enable rising: the first clock with run = 1 starts a fresh period at cnt 0, and period_start asserts.
- Arithmetic: slew comparisons are computed 9 bits wide. Results never wrap and are clamped to 0..255.

## Timing
- Reset (async, rst_n low):
  - run, pre, cnt, pending and duty_active clear to 0 immediately.
  - pwm_out = 0, period_start = 0, duty_active = 0.
  - Asserting reset mid-period aborts the period immediately.
  - Release is synchronous to the next clk edge. The block stays idle until enable is sampled high.
- Enable latency: enable is sampled at edge k, and run, pwm_out and period_start reflect it after edge k (one clock).
- Duty write latency: the new value appears on duty_active at the first wrap after the strobe edge. It never changes mid-period while running.
- High time per period = duty_active·PRESCALE clocks, starting at period_start.
- enable low mid-period:
  - pwm_out drops after the sampling edge.
  - The partial period is discarded and no period_start is generated.

## Configuration
- Macro: PWM_SLEW_LIMIT_EN.
- Defined: at each wrap duty_active moves toward target by at most MAX_STEP.
  - If target > active + MAX_STEP, then active + MAX_STEP.
  - If target < active − MAX_STEP, then active − MAX_STEP.
  - Otherwise, target.
  - The disabled-state direct load still bypasses the limiter.
- Undefined: duty_active ← target at each wrap; MAX_STEP is unused.

## Test plan
- Reset: with enable = 1 and duty 100, pull rst_n low mid-period with no clock edge. pwm_out, period_start and duty_active must read 0 immediately, and stay 0 after release until enable is sampled.
- PRESCALE = 1, duty 64 preset while disabled, then enable: pwm_out is high for 64 clocks and low for 191. period_start pulses every 255 clocks, with the first pulse on the first run cycle.
- Extremes: duty 0 gives pwm_out never high over 3 periods; duty 255 gives pwm_out always high over 3 periods; period_start still pulses every 255 clocks in both cases.
- Shadowing: with duty_active = 64, strobe 200 at cnt 30, then 180 at cnt 100. The current period stays at 64 high clocks, and the next period is 180 high. A strobe of 90 exactly on the wrap cycle applies to the immediately following period.
- Slew (PWM_SLEW_LIMIT_EN, MAX_STEP = 16): active 0 while running, write 100. Successive periods show duty 16, 32, 48, 64, 80, 96, 100. Writing 0 afterward steps down 84, 68, …, 4, 0.
- PRESCALE = 4, duty 10: high for 40 clocks per 1020-clock period. Deassert enable at cnt 50: pwm_out is low after the next edge and cnt reads 0. Re-enabling gives a period_start on the first run cycle.
